// File: rtl/yarvi_de_if.sv
// Fetch/execute <-> decode stage bundle.
// master: the surrounding pipeline (fetch drives fe_*, execute drives ex_*).
// slave : the decode stage, which drives the de_* outputs.
interface yarvi_de_if #(
  parameter int XLEN = 64,
  parameter int VMSB = 63
);
  // Fetch side
  logic [VMSB:0] fe_pc;
  logic [31:0]   fe_insn;

  // Execute side
  logic          ex_restart;
  logic [VMSB:0] ex_restart_pc;
  logic          ex_stall;

  // Decode outputs
  logic          de_restart;
  logic [VMSB:0] de_restart_pc;
  logic          de_valid;
  logic [VMSB:0] de_pc;
  logic [31:0]   de_insn;
  logic [4:0]    de_opcode;
  logic [4:0]    de_rd;
  logic [4:0]    de_rs1;
  logic [4:0]    de_rs2;
  logic [2:0]    de_funct3;
  logic [XLEN-1:0] de_imm;
  logic          de_illegal;

  modport master (
    output fe_pc, fe_insn, ex_restart, ex_restart_pc, ex_stall,
    input  de_restart, de_restart_pc, de_valid, de_pc, de_insn, de_opcode,
           de_rd, de_rs1, de_rs2, de_funct3, de_imm, de_illegal
  );

  // The execute redirect target goes straight to fetch; decode never needs it.
  modport slave (
    input  fe_pc, fe_insn, ex_restart, ex_stall,
    output de_restart, de_restart_pc, de_valid, de_pc, de_insn, de_opcode,
           de_rd, de_rs1, de_rs2, de_funct3, de_imm, de_illegal
  );
endinterface

// File: rtl/yarvi_de.sv
// Decode stage behind a free-running fetch. Registers the fetch pc/insn pair,
// pre-decodes register fields and the immediate, and tracks validity. Because
// fetch cannot stall, a word dropped while execute stalls is re-fetched by a
// one-shot replay redirect to de_pc+4; after reset a BOOT redirect to RESET_PC
// starts fetch.
module yarvi_de #(
  parameter int            XLEN     = 64,
  parameter int            VMSB     = 63,
  parameter logic [VMSB:0] RESET_PC = '0
) (
  input logic       clock,
  input logic       reset_n,
  yarvi_de_if.slave bus
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [VMSB:0] PC_STEP = (VMSB + 1)'(4);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  state_t        r_state;
  logic          r_replay;
  logic          r_valid;
  logic [VMSB:0] r_pc;
  logic [31:0]   r_insn;

  logic          w_boot;
  logic          w_restart;
  logic          w_hold;
  logic [4:0]    w_opcode;
  logic          w_sign;
  logic          w_known;
  logic [XLEN-1:0] w_imm;

  assign w_boot   = (r_state == ST_BOOT);
  // A pending replay fires once execute accepts the held insn, unless execute
  // is redirecting anyway (its target wins and the replay is dropped).
  assign w_restart = w_boot || (r_replay && !bus.ex_stall && !bus.ex_restart);
  // Only a live instruction is held; a stall over a bubble still captures.
  assign w_hold   = bus.ex_stall && r_valid;

  // Pipeline register and BOOT/RUN control; replay flag marks the HELD condition.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_BOOT;
      r_replay <= 1'b0;
      r_valid  <= 1'b0;
      r_pc     <= RESET_PC;
      r_insn   <= NOP;
    end else if (r_state == ST_BOOT) begin
      // Fetch word this cycle is pre-redirect garbage: never captured.
      r_state  <= ST_RUN;
      r_valid  <= 1'b0;
      r_replay <= 1'b0;
    end else if (bus.ex_restart) begin
      // Squash whatever is held; the fetch word this cycle is wrong-path.
      r_valid  <= 1'b0;
      r_replay <= 1'b0;
    end else if (w_restart) begin
      // Held insn is consumed this cycle; fetch word is about to be replaced.
      r_valid  <= 1'b0;
      r_replay <= 1'b0;
    end else if (w_hold) begin
      // Freeze de_*; the fetch word streaming past is lost and must be replayed.
      r_replay <= 1'b1;
    end else begin
      r_pc     <= bus.fe_pc;
      r_insn   <= bus.fe_insn;
      r_valid  <= 1'b1;
    end
  end

  assign w_opcode = r_insn[6:2];
  assign w_sign   = r_insn[31];

  // Immediate assembly and opcode legality, purely from the registered insn.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_imm   = '0;
    w_known = 1'b1;
    case (w_opcode)
      5'b00000, 5'b00100, 5'b00110, 5'b11001, 5'b11100:          // I-type
        w_imm = {{(XLEN-11){w_sign}}, r_insn[30:20]};
      5'b01000:                                                   // S-type
        w_imm = {{(XLEN-11){w_sign}}, r_insn[30:25], r_insn[11:7]};
      5'b11000:                                                   // B-type
        w_imm = {{(XLEN-12){w_sign}}, r_insn[7], r_insn[30:25], r_insn[11:8], 1'b0};
      5'b01101, 5'b00101:                                         // U-type
        w_imm = {{(XLEN-31){w_sign}}, r_insn[30:12], 12'h000};
      5'b11011:                                                   // J-type
        w_imm = {{(XLEN-20){w_sign}}, r_insn[19:12], r_insn[20], r_insn[30:21], 1'b0};
      5'b01100, 5'b01110, 5'b00011:                               // R-type / fence
        w_imm = '0;
      default:
        w_known = 1'b0;
    endcase
  end

  assign bus.de_restart    = w_restart;
  assign bus.de_restart_pc = w_boot ? RESET_PC : r_pc + PC_STEP;
  assign bus.de_valid      = r_valid;
  assign bus.de_pc         = r_pc;
  assign bus.de_insn       = r_insn;
  assign bus.de_opcode     = w_opcode;
  assign bus.de_rd         = r_insn[11:7];
  assign bus.de_rs1        = r_insn[19:15];
  assign bus.de_rs2        = r_insn[24:20];
  assign bus.de_funct3     = r_insn[14:12];
  assign bus.de_imm        = w_imm;
  assign bus.de_illegal    = !((r_insn[1:0] == 2'b11) && w_known);

endmodule

// File: tb/tb_yarvi_de.sv
// Bench for yarvi_de: a small fetch model feeds the decode stage, directed
// stimulus drives execute stall/restart, and a negedge monitor scores every
// instruction execute accepts and every decode redirect against queues of
// hand-computed expectations.
module tb_yarvi_de;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  exp_t        q_de[$];
  logic [63:0] q_rs[$];

  yarvi_de_if #(.XLEN(64), .VMSB(63)) bus ();

  yarvi_de #(.XLEN(64), .VMSB(63), .RESET_PC(64'h0)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents seen by fetch.
  function automatic logic [31:0] imem(input logic [63:0] pc);
    case (pc)
      64'h300: return 32'h00112223;  // sw   x1,4(x2)
      64'h304: return 32'hfe208ee3;  // beq  x1,x2,-4
      64'h308: return 32'h12345037;  // lui  x0,0x12345
      64'h30c: return 32'h00000000;  // illegal
      64'h310: return 32'h002081b3;  // add  x3,x1,x2
      64'h314: return 32'hfff0007b;  // unsupported opcode 11110
      64'h318: return 32'h80000017;  // auipc x0,0x80000
      default: return 32'hfff00093;  // addi x1,x0,-1
    endcase
  endfunction

  // Free-running fetch: execute redirect has priority over decode redirect.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)               bus.fe_pc <= 64'hdead_0000;
    else if (bus.ex_restart)    bus.fe_pc <= bus.ex_restart_pc;
    else if (bus.de_restart)    bus.fe_pc <= bus.de_restart_pc;
    else                        bus.fe_pc <= bus.fe_pc + 64'd4;
  end
  assign bus.fe_insn = imem(bus.fe_pc);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] insn,
                              input logic [4:0] opc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [63:0] imm,
                              input logic ill);
    exp_t e;
    e.pc = pc; e.insn = insn; e.opc = opc; e.rd = rd; e.rs1 = rs1;
    e.rs2 = rs2; e.f3 = f3; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t addi(input logic [63:0] pc);
    return mk(pc, 32'hfff00093, 5'h04, 5'd1, 5'd0, 5'd31, 3'd0, 64'hffff_ffff_ffff_ffff, 1'b0);
  endfunction

  // Scoreboard monitor: consumes on accept by execute, and on every redirect.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.de_valid && !bus.ex_stall && !bus.ex_restart) begin
        if (q_de.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_insn: got pc %h, none expected", bus.de_pc);
        end else begin
          exp_t e;
          e = q_de.pop_front();
          check("de_pc",      bus.de_pc,      e.pc);
          check("de_insn",    bus.de_insn,    e.insn);
          check("de_opcode",  bus.de_opcode,  e.opc);
          check("de_rd",      bus.de_rd,      e.rd);
          check("de_rs1",     bus.de_rs1,     e.rs1);
          check("de_rs2",     bus.de_rs2,     e.rs2);
          check("de_funct3",  bus.de_funct3,  e.f3);
          check("de_imm",     bus.de_imm,     e.imm);
          check("de_illegal", bus.de_illegal, e.ill);
        end
      end
      if (bus.de_restart) begin
        if (q_rs.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_restart: got target %h, none expected", bus.de_restart_pc);
        end else begin
          check("de_restart_pc", bus.de_restart_pc, q_rs.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid"},   bus.de_valid,      1'b0);
    check({tag, "_restart"}, bus.de_restart,    1'b1);
    check({tag, "_rpc"},     bus.de_restart_pc, 64'h0);
    check({tag, "_pc"},      bus.de_pc,         64'h0);
    check({tag, "_insn"},    bus.de_insn,       32'h00000013);
    check({tag, "_opcode"},  bus.de_opcode,     5'h04);
    check({tag, "_imm"},     bus.de_imm,        64'h0);
    check({tag, "_illegal"}, bus.de_illegal,    1'b0);
  endtask

  // Bounded wait until a live instruction at pc sits in decode.
  task automatic wait_pc(input logic [63:0] pc);
    int i;
    i = 0;
    while (!(bus.de_valid && bus.de_pc == pc) && i < 300) begin
      step();
      i++;
    end
    check("reach_pc",    bus.de_pc,    pc);
    check("reach_valid", bus.de_valid, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    bus.ex_stall = 1'b0;
    bus.ex_restart = 1'b0;
    bus.ex_restart_pc = 64'h0;

    // Expected accept order: boot stream to 0x100, replay redirect, 0x200,
    // format table at 0x300, then a second boot after the mid-stall reset.
    q_rs.push_back(64'h0);
    for (int a = 0; a <= 'h100; a += 4) q_de.push_back(addi(64'(a)));
    q_rs.push_back(64'h104);
    q_de.push_back(addi(64'h200));
    q_de.push_back(mk(64'h300, 32'h00112223, 5'h08, 5'd4,  5'd2, 5'd1,  3'd2, 64'd4, 1'b0));
    q_de.push_back(mk(64'h304, 32'hfe208ee3, 5'h18, 5'd29, 5'd1, 5'd2,  3'd0, 64'hffff_ffff_ffff_fffc, 1'b0));
    q_de.push_back(mk(64'h308, 32'h12345037, 5'h0d, 5'd0,  5'd8, 5'd3,  3'd5, 64'h0000_0000_1234_5000, 1'b0));
    q_de.push_back(mk(64'h30c, 32'h00000000, 5'h00, 5'd0,  5'd0, 5'd0,  3'd0, 64'h0, 1'b1));
    q_de.push_back(mk(64'h310, 32'h002081b3, 5'h0c, 5'd3,  5'd1, 5'd2,  3'd0, 64'h0, 1'b0));
    q_de.push_back(mk(64'h314, 32'hfff0007b, 5'h1e, 5'd0,  5'd0, 5'd31, 3'd0, 64'h0, 1'b1));
    q_de.push_back(mk(64'h318, 32'h80000017, 5'h05, 5'd0,  5'd0, 5'd0,  3'd0, 64'hffff_ffff_8000_0000, 1'b0));
    q_rs.push_back(64'h0);
    q_de.push_back(addi(64'h0));
    q_de.push_back(addi(64'h4));

    // Reset and boot redirect
    repeat (3) @(posedge clock);
    #1;
    chk_reset("rst");
    reset_n = 1'b1;
    #1;
    check("boot_restart", bus.de_restart,    1'b1);
    check("boot_rpc",     bus.de_restart_pc, 64'h0);
    check("boot_valid",   bus.de_valid,      1'b0);
    step();
    check("boot1_valid",   bus.de_valid,   1'b0);
    check("boot1_restart", bus.de_restart, 1'b0);
    step();
    check("first_valid", bus.de_valid, 1'b1);
    check("first_pc",    bus.de_pc,    64'h0);

    // Three-cycle stall at 0x100, then replay of 0x104 with one bubble
    wait_pc(64'h100);
    bus.ex_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("held_pc",      bus.de_pc,      64'h100);
      check("held_valid",   bus.de_valid,   1'b1);
      check("held_restart", bus.de_restart, 1'b0);
    end
    step();
    bus.ex_stall = 1'b0;
    #1;
    check("rel_restart", bus.de_restart,    1'b1);
    check("rel_rpc",     bus.de_restart_pc, 64'h104);
    step();
    check("bubble_valid", bus.de_valid, 1'b0);
    step();
    check("replay_pc",    bus.de_pc,    64'h104);
    check("replay_valid", bus.de_valid, 1'b1);

    // Execute restart in the cycle the replay would fire
    bus.ex_stall = 1'b1;
    step();
    bus.ex_stall = 1'b0;
    bus.ex_restart = 1'b1;
    bus.ex_restart_pc = 64'h200;
    #1;
    check("exr_beats_replay", bus.de_restart, 1'b0);
    step();
    bus.ex_restart = 1'b0;
    #1;
    check("exr_valid",      bus.de_valid,   1'b0);
    check("exr_replay_clr", bus.de_restart, 1'b0);
    step();
    check("exr_pc",    bus.de_pc,    64'h200);
    check("exr_valid2", bus.de_valid, 1'b1);

    // Execute restart while stalled squashes the held insn
    step();
    check("s_pc", bus.de_pc, 64'h204);
    bus.ex_stall = 1'b1;
    step();
    bus.ex_restart = 1'b1;
    bus.ex_restart_pc = 64'h300;
    #1;
    check("sq_restart", bus.de_restart, 1'b0);
    step();
    bus.ex_restart = 1'b0;
    bus.ex_stall = 1'b0;
    #1;
    check("sq_valid",   bus.de_valid,   1'b0);
    check("sq_restart2", bus.de_restart, 1'b0);
    step();
    check("sq_pc",    bus.de_pc,    64'h300);
    check("sq_valid2", bus.de_valid, 1'b1);

    // Formats stream through; reset asserted in the middle of a stall
    wait_pc(64'h31c);
    bus.ex_stall = 1'b1;
    step();
    check("pre_rst_pc", bus.de_pc, 64'h31c);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    bus.ex_stall = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("reboot_restart", bus.de_restart, 1'b1);
    check("reboot_valid",   bus.de_valid,   1'b0);
    step();
    step();
    check("reboot_pc",    bus.de_pc,    64'h0);
    check("reboot_valid2", bus.de_valid, 1'b1);
    step();
    step();
    bus.ex_stall = 1'b1;
    repeat (3) step();

    check("sb_de_left", 64'(q_de.size()), 64'd0);
    check("sb_rs_left", 64'(q_rs.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
